// File: rtl/serial_rb_loader_if.sv
// Serial-in / register-bank-out bundle for serial_rb_loader.
// SERIAL_RB_PARITY_EN adds the par_err status signal.
interface serial_rb_loader_if #(
  parameter int DATA_W = 18,
  parameter int ADDR_W = 3
);
  logic              sen;
  logic              sd;
  logic              rb_rw;
  logic [ADDR_W-1:0] rb_a;
  logic [DATA_W-1:0] rb_d;
  logic              done;
  logic              frame_err;
  logic [7:0]        pkt_cnt;
`ifdef SERIAL_RB_PARITY_EN
  logic              par_err;

  modport master (output sen, sd,
                  input  rb_rw, rb_a, rb_d, done, frame_err, pkt_cnt, par_err);
  modport slave  (input  sen, sd,
                  output rb_rw, rb_a, rb_d, done, frame_err, pkt_cnt, par_err);
`else
  modport master (output sen, sd,
                  input  rb_rw, rb_a, rb_d, done, frame_err, pkt_cnt);
  modport slave  (input  sen, sd,
                  output rb_rw, rb_a, rb_d, done, frame_err, pkt_cnt);
`endif
endinterface

// File: rtl/serial_rb_loader.sv
// Serial packet receiver: {addr, data[, parity]} MSB first framed by active-low sen,
// decoded into single-cycle register bank writes. Optional macro: SERIAL_RB_PARITY_EN.
module serial_rb_loader #(
  parameter int DATA_W  = 18,
  parameter int ADDR_W  = 3,
  parameter int NUM_PKT = 8
) (
  input  logic              clk,
  input  logic              rst,
  serial_rb_loader_if.slave bus
);

`ifdef SERIAL_RB_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int PKT_LEN = ADDR_W + DATA_W + PAR_W;
  localparam int CNT_W   = $clog2(PKT_LEN + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, WRITE, DONE} state_t;

  state_t              r_state;
  logic [PKT_LEN-2:0]  r_sh;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_rb_rw;
  logic [ADDR_W-1:0]   r_rb_a;
  logic [DATA_W-1:0]   r_rb_d;
  logic                r_done;
  logic                r_frame_err;
  logic [7:0]          r_pkt_cnt;

  // The final bit is never stored: the write is decoded from the shifter plus live sd.
  logic [PKT_LEN-1:0]  w_sh;
  logic [ADDR_W-1:0]   w_a;
  logic [DATA_W-1:0]   w_d;
  logic                w_par_ok;

  assign w_sh = {r_sh, bus.sd};
  assign w_a  = w_sh[PKT_LEN-1 -: ADDR_W];
  assign w_d  = w_sh[PAR_W +: DATA_W];

`ifdef SERIAL_RB_PARITY_EN
  logic r_par_err;
  assign w_par_ok    = ~(^w_sh);
  assign bus.par_err = r_par_err;
`else
  assign w_par_ok = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_sh        <= '0;
      r_cnt       <= '0;
      r_rb_rw     <= 1'b1;
      r_rb_a      <= '0;
      r_rb_d      <= '0;
      r_done      <= 1'b0;
      r_frame_err <= 1'b0;
      r_pkt_cnt   <= '0;
`ifdef SERIAL_RB_PARITY_EN
      r_par_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_rb_rw <= 1'b1;
          if (!bus.sen) begin
            r_sh    <= (PKT_LEN-1)'(bus.sd);
            r_cnt   <= CNT_W'(1);
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          if (bus.sen) begin
            r_frame_err <= 1'b1;
            r_sh        <= '0;
            r_state     <= IDLE;
          end else begin
            r_sh  <= w_sh[PKT_LEN-2:0];
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(PKT_LEN-1)) begin
              if (w_par_ok) begin
                r_rb_rw <= 1'b0;
                r_rb_a  <= w_a;
                r_rb_d  <= w_d;
                if (r_pkt_cnt != 8'(NUM_PKT))
                  r_pkt_cnt <= r_pkt_cnt + 8'd1;
                r_state <= WRITE;
              end else begin
`ifdef SERIAL_RB_PARITY_EN
                r_par_err <= 1'b1;
`endif
                r_state <= IDLE;
              end
            end
          end
        end
        WRITE: begin
          r_rb_rw <= 1'b1;
          if (r_pkt_cnt == 8'(NUM_PKT)) begin
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_state <= IDLE;
          end
        end
        DONE: begin
          r_rb_rw <= 1'b1;
          r_state <= DONE;
        end
      endcase
    end
  end

  assign bus.rb_rw     = r_rb_rw;
  assign bus.rb_a      = r_rb_a;
  assign bus.rb_d      = r_rb_d;
  assign bus.done      = r_done;
  assign bus.frame_err = r_frame_err;
  assign bus.pkt_cnt   = r_pkt_cnt;

endmodule

// File: tb/tb_serial_rb_loader.sv
// Scoreboard bench for serial_rb_loader: directed packets push expected writes,
// a negedge monitor pops and checks address, data and strobe cycle.
module tb_serial_rb_loader;
  localparam int DATA_W  = 18;
  localparam int ADDR_W  = 3;
  localparam int NUM_PKT = 8;
`ifdef SERIAL_RB_PARITY_EN
  localparam int PL = ADDR_W + DATA_W + 1;
`else
  localparam int PL = ADDR_W + DATA_W;
`endif

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    int unsigned       cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mon_en = 1'b0;
  int unsigned cyc = 0;
  int unsigned total = 0;
  int unsigned bad = 0;
  exp_t        q[$];

  serial_rb_loader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  serial_rb_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_PKT(NUM_PKT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_en && !rst && bus.rb_rw === 1'b0) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got a=%0h d=%0h want no write", bus.rb_a, bus.rb_d);
      end else begin
        e = q.pop_front();
        chk("wr_addr", 32'(bus.rb_a), 32'(e.a));
        chk("wr_data", 32'(bus.rb_d), 32'(e.d));
        chk("wr_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic gap(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.sen = 1'b1;
      bus.sd  = 1'b0;
    end
  endtask

  task automatic send(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                      input int nbits, input bit exp_wr, input bit bad_par);
    logic [PL-1:0] pkt;
`ifdef SERIAL_RB_PARITY_EN
    pkt = {a, d, (^{a, d}) ^ bad_par};
`else
    pkt = {a, d};
    if (bad_par) pkt = {a, d};
`endif
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      bus.sen = 1'b0;
      bus.sd  = pkt[PL-1-i];
    end
    if (exp_wr) q.push_back('{a, d, cyc + 1});
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst     = 1'b1;
    bus.sen = 1'b1;
    bus.sd  = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_reset_vals;
    chk("rst_rb_rw", 32'(bus.rb_rw), 32'd1);
    chk("rst_rb_a", 32'(bus.rb_a), 32'd0);
    chk("rst_rb_d", 32'(bus.rb_d), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_frame_err", 32'(bus.frame_err), 32'd0);
    chk("rst_pkt_cnt", 32'(bus.pkt_cnt), 32'd0);
`ifdef SERIAL_RB_PARITY_EN
    chk("rst_par_err", 32'(bus.par_err), 32'd0);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end

  initial begin
    bus.sen = 1'b1;
    bus.sd  = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_reset_vals();
    mon_en = 1'b1;

    // single packet: addr 5, data 18'h2A5A5
    send(3'd5, 18'h2A5A5, PL, 1'b1, 1'b0);
    gap(3);
    chk("t1_pkt_cnt", 32'(bus.pkt_cnt), 32'd1);
    chk("t1_rb_rw_idle", 32'(bus.rb_rw), 32'd1);
    chk("t1_rb_a_hold", 32'(bus.rb_a), 32'd5);
    chk("t1_rb_d_hold", 32'(bus.rb_d), 32'h2A5A5);

    // duplicate address overwrite
    do_reset();
    send(3'd2, 18'h00001, PL, 1'b1, 1'b0);
    gap(1);
    send(3'd2, 18'h3FFFF, PL, 1'b1, 1'b0);
    gap(3);
    chk("dup_pkt_cnt", 32'(bus.pkt_cnt), 32'd2);
    chk("dup_rb_d", 32'(bus.rb_d), 32'h3FFFF);

    // truncated frame then a good packet
    do_reset();
    send(3'd6, 18'h0F0F0, 10, 1'b0, 1'b0);
    gap(2);
    chk("trunc_frame_err", 32'(bus.frame_err), 32'd1);
    chk("trunc_pkt_cnt", 32'(bus.pkt_cnt), 32'd0);
    send(3'd3, 18'h12345, PL, 1'b1, 1'b0);
    gap(3);
    chk("after_trunc_pkt_cnt", 32'(bus.pkt_cnt), 32'd1);
    chk("after_trunc_frame_err", 32'(bus.frame_err), 32'd1);

    // reset mid-packet at bit 12
    send(3'd4, 18'h2AAAA, 12, 1'b0, 1'b0);
    @(negedge clk);
    rst     = 1'b1;
    bus.sen = 1'b1;
    #1;
    chk_reset_vals();
    @(negedge clk);
    rst = 1'b0;
    gap(2);
    chk("post_rst_frame_err", 32'(bus.frame_err), 32'd0);

    // eight back-to-back packets, addr 7..0, data addr*3
    for (int a = 7; a >= 0; a--) begin
      send(3'(a), 18'(a * 3), PL, 1'b1, 1'b0);
      gap(1);
    end
    chk("done_not_yet", 32'(bus.done), 32'd0);
    gap(1);
    chk("done_set", 32'(bus.done), 32'd1);
    chk("full_pkt_cnt", 32'(bus.pkt_cnt), 32'd8);
    send(3'd1, 18'h11111, PL, 1'b0, 1'b0);
    gap(3);
    chk("ninth_pkt_cnt", 32'(bus.pkt_cnt), 32'd8);
    chk("ninth_done", 32'(bus.done), 32'd1);
    chk("ninth_rb_a", 32'(bus.rb_a), 32'd0);

`ifdef SERIAL_RB_PARITY_EN
    do_reset();
    send(3'd1, 18'h00003, PL, 1'b0, 1'b1);
    gap(3);
    chk("par_err_set", 32'(bus.par_err), 32'd1);
    chk("par_pkt_cnt", 32'(bus.pkt_cnt), 32'd0);
    send(3'd1, 18'h00003, PL, 1'b1, 1'b0);
    gap(3);
    chk("par_good_pkt_cnt", 32'(bus.pkt_cnt), 32'd1);
`endif

    chk("queue_drained", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/serial_rb_loader.md
# serial_rb_loader

Parametrised serial-to-parallel packet receiver that fills a single-port register bank. Each packet carries its own destination address and a data word, both MSB first, framed by an active-low enable. The block decodes the address rather than writing sequentially, detects truncated frames, and asserts `done` after a programmed number of good packets. It sits between the serial input pins and the register bank write port.

## Interface
- `DATA_W`, default 18: data word width in bits, 1..32.
- `ADDR_W`, default 3: register bank address width in bits, 1..8.
- `NUM_PKT`, default 8: number of good packets to accept before `done`, 1..255.
- `clk`  in  1  clock; all logic is rising-edge triggered.
- `rst`  in  1  reset, asynchronous, active-high.
- `sen`  in  1  frame enable, active low; `sd` is valid while it is 0.
- `sd`  in  1  serial data, one bit per clock.
- `rb_rw`  out  1  bank read/write strobe; 1 = idle/read, 0 = write this cycle.
- `rb_a`  out  ADDR_W  bank write address.
- `rb_d`  out  DATA_W  bank write data.
- `done`  out  1  set after `NUM_PKT` good packets; sticky until reset.
- `frame_err`  out  1  sticky; set when a frame is truncated.
- `pkt_cnt`  out  8  number of good packets written; saturates at `NUM_PKT`.

## Operation
- Packet format: `ADDR_W` address bits MSB first, then `DATA_W` data bits MSB first.
  - With parity enabled, one parity bit follows the data.
  - `PKT_LEN` = `ADDR_W + DATA_W` (+1 with parity).
- The state machine has four states: IDLE, SHIFT, WRITE, DONE.
- IDLE:
  - `rb_rw` = 1.
  - On an edge with `sen` = 0, shift in `sd` as address bit MSB, set the bit counter to 1 and go to SHIFT.
- SHIFT:
  - On each edge with `sen` = 0, shift `sd` in and increment the counter.
  - When the bit that brings the count to `PKT_LEN` is sampled, go to WRITE.
  - If `sen` = 1 on any edge in SHIFT: set `frame_err`, discard the partial packet, go to IDLE. No write occurs.
- WRITE, lasting exactly one cycle:
  - `rb_rw` = 0, `rb_a` = captured address, `rb_d` = captured data.
  - Increment `pkt_cnt`.
  - Next state is DONE if `pkt_cnt` has reached `NUM_PKT`, otherwise IDLE.
  - `sd` and `sen` are ignored during WRITE. `sen` = 0 here is not an error.
- DONE: `done` = 1, `rb_rw` = 1. All input is ignored until reset.
- `rb_a` and `rb_d` hold their last written values outside WRITE.
- Any address value is legal. Duplicate addresses overwrite; the bank is not checked for coverage.
- Reset values: `rb_rw` = 1, `rb_a` = 0, `rb_d` = 0, `done` = 0, `frame_err` = 0, `pkt_cnt` = 0; state IDLE, shift register cleared.
- Reset mid-packet aborts immediately. No write is issued and no error is flagged.

## Timing
- Bit i of a packet is sampled on edge E_i, i = 0..PKT_LEN-1.
- Edge E_(PKT_LEN-1) registers WRITE. `rb_rw` = 0 is visible for the single cycle between E_(PKT_LEN-1) and E_PKT_LEN.
- Latency is one cycle from the last bit sampled to the write strobe.
- Minimum inter-packet gap is one cycle (the WRITE cycle). The next packet's first bit may be sampled at E_PKT_LEN + 1.
- `done` rises on the same edge that ends the final WRITE cycle.
- `pkt_cnt` updates on the edge that enters WRITE.
- `frame_err` is registered on the edge at which `sen` = 1 is sampled in SHIFT.

## Configuration
- `SERIAL_RB_PARITY_EN` defined:
  - Packets carry a trailing even-parity bit covering address and data.
  - On mismatch: suppress the write, set sticky output `par_err` (1 bit, reset 0), leave `pkt_cnt` unchanged, return to IDLE.
- Not defined: no parity bit is expected, the port `par_err` does not exist, and `PKT_LEN` = `ADDR_W + DATA_W`.

## Test plan
- Defaults, no parity: send addr 5, data 18'h2A5A5 (21 bits, `sen` low 21 cycles) -> one cycle of `rb_rw` = 0 with `rb_a` = 5, `rb_d` = 18'h2A5A5, one cycle after the last bit; `pkt_cnt` = 1.
- Eight back-to-back packets to addresses 7,6,…,0 with data = addr×3, 1-cycle gaps -> eight single-cycle writes in that order; `done` = 1 after the 8th; a 9th packet produces no write.
- `sen` released after 10 bits -> `frame_err` = 1, no write, `pkt_cnt` unchanged; the following full packet is written correctly.
- Reset asserted mid-packet (bit 12) -> all outputs at reset values immediately; no write, `frame_err` = 0.
- Two packets to addr 2 (data 1, then 18'h3FFFF) -> two writes to addr 2, the last with data 18'h3FFFF; `pkt_cnt` = 2.
- With `SERIAL_RB_PARITY_EN`: a packet with a wrong parity bit -> no write, `par_err` = 1, `pkt_cnt` unchanged; a correct-parity packet is written normally.
